// File: rtl/ring_johnson_decoder_pkg.sv
// ring_johnson_decoder_pkg: FSM states, code sizes and code tables for the ring/Johnson decoder
package ring_johnson_decoder_pkg;
    typedef enum logic [1:0] {HUNT = 2'd0, TRACK = 2'd1, LOCKED = 2'd2} state_t;
    localparam int N_JOHNSON = 8;
    localparam int N_RING = 4;
    localparam logic [N_JOHNSON-1:0][3:0] JOHNSON_TAB = {
        4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000
    };
    localparam logic [N_RING-1:0][3:0] RING_TAB = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
endpackage

// File: rtl/ring_johnson_decoder_lut.sv
// jr_code_lut: combinational code-to-index lookup for Johnson (mode=1) or one-hot ring (mode=0)
module jr_code_lut
    import ring_johnson_decoder_pkg::*;
(
    input  logic       mode,
    input  logic [3:0] code,
    output logic [2:0] index,
    output logic       legal
);
    always_comb begin
        index = 3'd0;
        legal = 1'b0;
        for (int i = 0; i < N_JOHNSON; i++)
            if (mode && code == JOHNSON_TAB[i]) begin
                index = 3'(i);
                legal = 1'b1;
            end
        for (int i = 0; i < N_RING; i++)
            if (!mode && code == RING_TAB[i]) begin
                index = 3'(i);
                legal = 1'b1;
            end
    end
endmodule

// File: rtl/ring_johnson_decoder.sv
// ring_johnson_decoder: decodes sampled ring/Johnson counter codes, tracks stepping and reports lock/errors
module ring_johnson_decoder
    import ring_johnson_decoder_pkg::*;
#(
    parameter int LOCK_STEPS = 2,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_en,
    input  logic             mode,
    input  logic [3:0]       code,
    output logic [2:0]       index,
    output logic             index_vld,
    output logic             locked,
    output logic             code_err,
    output logic             step_err,
    output logic             wrap,
    output logic [ERR_W-1:0] err_cnt
);
    state_t     state, state_d;
    logic [2:0] step_cnt, cnt_d, cnt_inc, lut_idx, last, succ;
    logic       mode_q, legal, hunt, is_succ, c_err, s_err, vld, wrap_d;

    jr_code_lut u_lut (.mode(mode), .code(code), .index(lut_idx), .legal(legal));

    always_comb begin
        hunt    = state == HUNT || mode != mode_q;
        last    = mode ? 3'(N_JOHNSON - 1) : 3'(N_RING - 1);
        succ    = index == last ? 3'd0 : index + 3'd1;
        is_succ = !hunt && lut_idx == succ;
        vld     = sample_en && legal;
        c_err   = sample_en && !legal;
        s_err   = vld && !hunt && !is_succ;
        wrap_d  = vld && is_succ && state == LOCKED && lut_idx == 3'd0;
        cnt_inc = step_cnt + 3'd1;
        state_d = !sample_en ? state :
                  !legal ? HUNT :
                  !is_succ ? TRACK :
                  (state == TRACK && cnt_inc == 3'(LOCK_STEPS)) ? LOCKED : state;
        cnt_d   = !sample_en ? step_cnt :
                  !is_succ ? 3'd0 :
                  state == TRACK ? cnt_inc : step_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            step_cnt  <= 3'd0;
            mode_q    <= 1'b0;
            index     <= 3'd0;
            index_vld <= 1'b0;
            locked    <= 1'b0;
            code_err  <= 1'b0;
            step_err  <= 1'b0;
            wrap      <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_d;
            step_cnt  <= cnt_d;
            mode_q    <= sample_en ? mode : mode_q;
            index     <= vld ? lut_idx : index;
            index_vld <= vld;
            locked    <= state_d == LOCKED;
            code_err  <= c_err;
            step_err  <= s_err;
            wrap      <= wrap_d;
            err_cnt   <= ((c_err || s_err) && err_cnt != '1) ? err_cnt + 1'b1 : err_cnt;
        end
    end
endmodule
